// File: rtl/sample_dma.sv
// Multi-channel sample DMA: drains per-channel FIFOs into SDRAM through a
// single-beat write port, serving channels round-robin one word at a time.
module sample_dma #(
  parameter int CHW = 1,
  parameter int AW  = 24,
  parameter int DW  = 16,
  localparam int CHANNELS = 1 << CHW
) (
  input  logic                   clk_48,
  input  logic                   rst_n,
  input  logic [CHANNELS-1:0]    fifo_empty,
  output logic [CHANNELS-1:0]    fifo_rd,
  input  logic [CHANNELS*DW-1:0] fifo_data,
  output logic [AW-1:0]          awaddr,
  output logic [DW-1:0]          wdata,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [CHW+1:0]         reg_addr,
  input  logic [31:0]            reg_wdata,
  input  logic                   reg_wvalid,
  output logic [31:0]            reg_rdata,
  output logic                   busy,
  output logic [CHANNELS-1:0]    done
);

  localparam int CW = (CHW > 0) ? CHW : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_BASE = 2'd1;
  localparam logic [1:0] R_LEN  = 2'd2;
  localparam logic [1:0] R_PTR  = 2'd3;

  state_t              state;
  logic [CW-1:0]       cur_ch;
  logic [CW-1:0]       last;
  logic                clr_pend;

  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] done_q;
  logic [CHANNELS-1:0] wrapped;
  logic [AW-1:0]       base [CHANNELS];
  logic [AW-1:0]       len  [CHANNELS];
  logic [AW-1:0]       ptr  [CHANNELS];

  logic [CHANNELS-1:0] eligible;
  logic [DW-1:0]       fifo_word [CHANNELS];
  logic                grant_valid;
  logic [CW-1:0]       grant_ch;
  logic [CW-1:0]       reg_ch;
  logic [1:0]          reg_idx;
  logic                handshake;
  logic                clr_hit;
  logic [AW-1:0]       next_ptr;
  logic                unused_bits;

  assign reg_ch      = CW'(reg_addr >> 2);
  assign reg_idx     = reg_addr[1:0];
  assign handshake   = (state == S_WAIT) && wready;
  assign clr_hit     = reg_wvalid && (reg_idx == R_CTRL) && reg_wdata[2] && (reg_ch == cur_ch);
  assign next_ptr    = ptr[cur_ch] + 1'b1;
  assign done        = done_q;
  assign unused_bits = ^reg_wdata;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eligible[i]  = enable[i] && !done_q[i] && !fifo_empty[i] && (len[i] != '0);
      fifo_word[i] = fifo_data[i*DW +: DW];
    end
  end

  // Scan starts one past the last granted channel so every channel gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = last;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!grant_valid && eligible[CW'((int'(last) + k) % CHANNELS)]) begin
        grant_valid = 1'b1;
        grant_ch    = CW'((int'(last) + k) % CHANNELS);
      end
    end
  end

  // NOTE: every output is assigned a default before the case, so no latch is inferred.
  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      R_CTRL: begin
        reg_rdata[0] = enable[reg_ch];
        reg_rdata[1] = wrap[reg_ch];
        reg_rdata[8] = done_q[reg_ch];
        reg_rdata[9] = wrapped[reg_ch];
      end
      R_BASE:  reg_rdata = 32'(base[reg_ch]);
      R_LEN:   reg_rdata = 32'(len[reg_ch]);
      R_PTR:   reg_rdata = 32'(ptr[reg_ch]);
      default: reg_rdata = '0;
    endcase
  end

  // NOTE: the register arrays are tiny flop banks that software expects to read 0
  // after reset, so they are reset explicitly rather than treated as a RAM.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      enable  <= '0;
      wrap    <= '0;
      done_q  <= '0;
      wrapped <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
        ptr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (enable[i] && (len[i] == '0))
          done_q[i] <= 1'b1;

        if (handshake && (cur_ch == CW'(i)) && !clr_pend) begin
          if (next_ptr == len[i]) begin
            if (wrap[i]) begin
              ptr[i]     <= '0;
              wrapped[i] <= 1'b1;
            end else begin
              ptr[i]    <= next_ptr;
              done_q[i] <= 1'b1;
            end
          end else begin
            ptr[i] <= next_ptr;
          end
        end

        // Register writes come last so a clear overrides a same-cycle handshake update.
        if (reg_wvalid && (reg_ch == CW'(i))) begin
          case (reg_idx)
            R_CTRL: begin
              enable[i] <= reg_wdata[0];
              wrap[i]   <= reg_wdata[1];
              if (reg_wdata[2]) begin
                ptr[i]     <= '0;
                done_q[i]  <= 1'b0;
                wrapped[i] <= 1'b0;
              end
            end
            R_BASE:  base[i] <= reg_wdata[AW-1:0];
            R_LEN:   len[i]  <= reg_wdata[AW-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in the same cycle (fifo_rd default, then the granted bit) deliberately win.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_ch   <= '0;
      last     <= CW'(CHANNELS - 1);
      clr_pend <= 1'b0;
      fifo_rd  <= '0;
      awaddr   <= '0;
      wdata    <= '0;
      wvalid   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fifo_rd <= '0;
      if (clr_hit && (state != S_IDLE))
        clr_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            cur_ch            <= grant_ch;
            last              <= grant_ch;
            fifo_rd[grant_ch] <= 1'b1;
            busy              <= 1'b1;
            clr_pend          <= 1'b0;
            state             <= S_FETCH;
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          wdata  <= fifo_word[cur_ch];
          awaddr <= base[cur_ch] + ptr[cur_ch];
          wvalid <= 1'b1;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (wready) begin
            wvalid <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
